// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package addsub_pkg;

   // Condition flags returned alongside every result.
   typedef struct packed {
      logic c;   // raw carry-out of the MSB (1 = no borrow on subtract)
      logic v;   // signed overflow
      logic z;   // result is zero
      logic n;   // result MSB
   } flags_t;

   // Width of one carry-chained segment.
   function automatic int seg_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// One SEG-bit slice of the carry chain: sum and carry-out of a + b + cin.
module addsub_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   logic [SEG:0] total_s;

   // Plain ripple add, one bit wider to expose the carry-out.
   always_comb begin
      total_s = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
   end

   assign sum  = total_s[SEG-1:0];
   assign cout = total_s[SEG];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chained segments.
// Stage k adds segment k (LSB first) using the carry registered by stage k-1;
// unconsumed operand bits and finished result bits travel with the operation
// so the whole result leaves the last stage aligned. A single global advance
// enable stalls every stage together when the consumer holds off.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   input  logic             cin,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n,
   output logic [TAG_W-1:0] tag_out
);

   localparam int SEG = seg_width(WIDTH, STAGES);

   // Everything one operation carries between stages. The operand fields
   // hold the effective (already inverted for subtract) B so later stages
   // never need op_sub.
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] y;
   } stage_t;

   stage_t         stage_r [STAGES];
   stage_t         src_s   [STAGES];
   stage_t         nxt_s   [STAGES];
   stage_t         final_s;
   logic [SEG-1:0] sum_s   [STAGES];
   logic           cout_s  [STAGES];
   flags_t         flags_s;
   flags_t         flags_r;
   logic           adv_s;

   // Whole pipeline moves only when the output slot is empty or being taken.
   assign adv_s    = !stage_r[STAGES-1].valid || out_ready;
   assign in_ready = adv_s;

   // Stage inputs: stage 0 takes the ports, later stages their predecessor.
   always_comb begin
      src_s[0].valid = in_valid;
      src_s[0].carry = op_sub ? 1'b1 : cin;
      src_s[0].tag   = tag;
      src_s[0].a     = a;
      src_s[0].b     = op_sub ? ~b : b;
      src_s[0].y     = {WIDTH{1'b0}};
      for (int k = 1; k < STAGES; k++) begin
         src_s[k] = stage_r[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      addsub_segment #(
         .SEG (SEG)
      ) u_seg (
         .a    (src_s[k].a[k*SEG +: SEG]),
         .b    (src_s[k].b[k*SEG +: SEG]),
         .cin  (src_s[k].carry),
         .sum  (sum_s[k]),
         .cout (cout_s[k])
      );
   end

   // Merge each segment's sum and carry into the operation it belongs to.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         nxt_s[k]                  = src_s[k];
         nxt_s[k].carry            = cout_s[k];
         nxt_s[k].y[k*SEG +: SEG]  = sum_s[k];
      end
   end

   assign final_s = nxt_s[STAGES-1];

   // Flags from the completed result of the last segment.
   always_comb begin
      flags_s   = 4'b0000;
      flags_s.c = final_s.carry;
      flags_s.n = final_s.y[WIDTH-1];
      flags_s.z = (final_s.y == {WIDTH{1'b0}});
      flags_s.v = (final_s.a[WIDTH-1] == final_s.b[WIDTH-1]) &&
                  (final_s.y[WIDTH-1] != final_s.a[WIDTH-1]);
   end

   // Stage registers and flags: cleared on reset, frozen while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_r[k] <= '0;
         end
         flags_r <= 4'b0000;
      end else if (adv_s) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_r[k] <= nxt_s[k];
         end
         flags_r <= flags_s;
      end
   end

   assign out_valid = stage_r[STAGES-1].valid;
   assign y         = stage_r[STAGES-1].y;
   assign tag_out   = stage_r[STAGES-1].tag;
   assign flag_c    = flags_r.c;
   assign flag_v    = flags_r.v;
   assign flag_z    = flags_r.z;
   assign flag_n    = flags_r.n;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=32, STAGES=4, TAG_W=4).
module tb_pipelined_addsub;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;
   localparam int TAG_W  = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic             cin;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             flag_c;
   logic             flag_v;
   logic             flag_z;
   logic             flag_n;
   logic [TAG_W-1:0] tag_out;

   pipelined_addsub #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op_sub    (op_sub),
      .cin       (cin),
      .tag       (tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_z    (flag_z),
      .flag_n    (flag_n),
      .tag_out   (tag_out)
   );

   always #5 clk = ~clk;

   // Stimulus vector with hand-computed result; ef = {c, v, z, n}.
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op_sub;
      logic        cin;
      logic [3:0]  tag;
      logic [31:0] ey;
      logic [3:0]  ef;
   } vec_t;

   typedef struct {
      logic [31:0] ey;
      logic [3:0]  ef;
      logic [3:0]  etag;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t exp_q[$];
   vec_t dir_v[8];
   vec_t str_v[8];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                               input logic vs, input logic vc, input logic [3:0] vt,
                               input logic [31:0] vy, input logic [3:0] vf);
      vec_t v;
      v.a = va; v.b = vb; v.op_sub = vs; v.cin = vc; v.tag = vt; v.ey = vy; v.ef = vf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Present one operation, wait (bounded) for acceptance, record the expectation.
   task automatic issue(input vec_t v, input bit lat);
      exp_t e;
      bit   rdy;
      int   guard;
      a = v.a; b = v.b; op_sub = v.op_sub; cin = v.cin; tag = v.tag;
      in_valid = 1'b1;
      rdy = 1'b0;
      guard = 0;
      while (!rdy && guard < 100) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         guard++;
      end
      #1;
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout tag=%h actual=not_accepted required=accepted", v.tag);
      end else begin
         e.ey = v.ey; e.ef = v.ef; e.etag = v.tag; e.acc = cyc; e.lat = lat;
         exp_q.push_back(e);
      end
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected result has been seen.
   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
      end
   endtask

   // Monitor: handshake rule, stall stability and scoreboard comparison.
   initial begin
      exp_t        e;
      bit          held_valid;
      logic [31:0] held_y;
      logic [3:0]  held_tag;
      held_valid = 1'b0;
      held_y     = 32'h0;
      held_tag   = 4'h0;
      forever begin
         @(negedge clk);
         chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
         if (held_valid && out_valid) begin
            chk("stall_y_stable", y, held_y);
            chk("stall_tag_stable", {28'b0, tag_out}, {28'b0, held_tag});
         end
         held_valid = out_valid && !out_ready && !reset;
         held_y     = y;
         held_tag   = tag_out;
         if (held_valid) stall_cnt++;
         if (out_valid && out_ready && !reset) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=y_%h_tag_%h required=none", y, tag_out);
            end else begin
               e = exp_q.pop_front();
               chk("result_y", y, e.ey);
               chk("result_flags_cvzn", {28'b0, flag_c, flag_v, flag_z, flag_n}, {28'b0, e.ef});
               chk("result_tag", {28'b0, tag_out}, {28'b0, e.etag});
               if (e.lat) chk("latency_edges", cyc - e.acc + 1, STAGES);
            end
         end
      end
   end

   // Hard stop in case anything wedges.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      dir_v[0] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00000000, 4'b1010);
      dir_v[1] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h2, 32'h80000000, 4'b0101);
      dir_v[2] = mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 4'h3, 32'h00000100, 4'b0000);
      dir_v[3] = mk(32'h00000005, 32'h00000007, 1'b1, 1'b0, 4'h4, 32'hFFFFFFFE, 4'b0001);
      dir_v[4] = mk(32'h80000000, 32'h00000001, 1'b1, 1'b0, 4'h5, 32'h7FFFFFFF, 4'b1100);
      dir_v[5] = mk(32'h00000010, 32'h00000020, 1'b0, 1'b1, 4'hA, 32'h00000031, 4'b0000);
      dir_v[6] = mk(32'h0000000A, 32'h0000000A, 1'b1, 1'b1, 4'hB, 32'h00000000, 4'b1010);
      dir_v[7] = mk(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 4'hC, 32'h01000000, 4'b0000);

      str_v[0] = mk(32'h00000001, 32'h00000002, 1'b0, 1'b0, 4'h0, 32'h00000003, 4'b0000);
      str_v[1] = mk(32'h11111111, 32'h22222222, 1'b0, 1'b0, 4'h1, 32'h33333333, 4'b0000);
      str_v[2] = mk(32'h12345678, 32'h87654321, 1'b0, 1'b0, 4'h2, 32'h99999999, 4'b0001);
      str_v[3] = mk(32'h00000100, 32'h00000001, 1'b1, 1'b0, 4'h3, 32'h000000FF, 4'b1000);
      str_v[4] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'h4, 32'h00000000, 4'b1110);
      str_v[5] = mk(32'h00000000, 32'h00000001, 1'b1, 1'b0, 4'h5, 32'hFFFFFFFF, 4'b0001);
      str_v[6] = mk(32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 4'h6, 32'hDEADBEF0, 4'b0001);
      str_v[7] = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h7, 32'h80000000, 4'b0101);

      // Reset with a request pending: it must be ignored.
      reset = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; a = 32'h12345678; b = 32'h1; op_sub = 1'b0; cin = 1'b0; tag = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_y", y, 32'h0);
      chk("reset_flags", {28'b0, flag_c, flag_v, flag_z, flag_n}, 32'd0);
      chk("reset_tag_out", {28'b0, tag_out}, 32'd0);
      chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Directed back-to-back operations, no back-pressure.
      for (int i = 0; i < 8; i++) issue(dir_v[i], 1'b1);
      drain();

      // Streamed operations with a 3-cycle consumer stall mid-stream.
      stall_cnt = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) issue(str_v[i], 1'b0);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_cycles", stall_cnt, 32'd3);

      // Reset while three operations are in flight, with a request during reset.
      for (int i = 0; i < 3; i++) issue(dir_v[i], 1'b1);
      reset = 1'b1;
      exp_q.delete();
      in_valid = 1'b1; a = 32'h0000FFFF; b = 32'h00000001; op_sub = 1'b0; cin = 1'b0; tag = 4'h9;
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      chk("post_reset_y", y, 32'h0);
      chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      issue(mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 4'h5, 32'h00000100, 4'b0000), 1'b1);
      drain();
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
